// File: rtl/image_buffer_reader.sv
// Streams the compressed image out of the image buffer as a valid/ready byte stream.
// Reads from address 0 up to bytes_available_in while the writer may still be filling it.
module image_buffer_reader #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clock_in,
    input  logic                     reset_n_in,
    input  logic                     start_in,
    input  logic                     abort_in,
    input  logic [ADDRESS_WIDTH-1:0] bytes_available_in,
    input  logic                     image_complete_in,
    output logic                     buffer_read_enable_out,
    output logic [ADDRESS_WIDTH-1:0] buffer_address_out,
    input  logic [DATA_WIDTH-1:0]    buffer_data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid_out,
    input  logic                     data_ready_in,
    output logic [ADDRESS_WIDTH-1:0] bytes_read_out,
    output logic                     busy_out,
    output logic                     done_out
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] issue_q, issue_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH-1:0] bytes_read_q, bytes_read_d;
    logic                     inflight_q, inflight_d;
    logic [1:0]               count_q, count_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     done_q, done_d;
    logic [DATA_WIDTH-1:0]    mem_q [2];

    logic       strobe;
    logic       push;
    logic       pop;
    logic       valid;
    logic [1:0] occupancy;

    assign valid     = (count_q != 2'd0);
    assign occupancy = count_q + {1'b0, inflight_q};
    // Issue depends only on registered state and non-stream inputs, never on data_ready_in.
    assign strobe    = (state_q == ST_STREAM) && !abort_in &&
                       (issue_q < bytes_available_in) && (occupancy < 2'd2);
    assign push      = inflight_q && !abort_in;
    assign pop       = valid && data_ready_in;

    always_comb begin
        state_d      = state_q;
        issue_d      = issue_q;
        addr_d       = addr_q;
        bytes_read_d = bytes_read_q;
        inflight_d   = strobe;
        count_d      = count_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d     = rd_ptr_q ^ pop;
        wr_ptr_d     = wr_ptr_q ^ push;
        done_d       = 1'b0;

        if (strobe) begin
            issue_d = issue_q + 1'b1;
            addr_d  = issue_q;
        end
        if (pop) begin
            bytes_read_d = bytes_read_q + 1'b1;
        end

        if (abort_in) begin
            state_d    = ST_IDLE;
            inflight_d = 1'b0;
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_in) begin
                        state_d      = ST_STREAM;
                        issue_d      = '0;
                        bytes_read_d = '0;
                        inflight_d   = 1'b0;
                        count_d      = 2'd0;
                        rd_ptr_d     = 1'b0;
                        wr_ptr_d     = 1'b0;
                    end
                end
                default: begin
                    // Completion is judged on next-state values so done lands the cycle after the last transfer.
                    if (image_complete_in && (bytes_read_d == bytes_available_in) &&
                        (count_d == 2'd0) && !inflight_d) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q      <= ST_IDLE;
            issue_q      <= '0;
            addr_q       <= '0;
            bytes_read_q <= '0;
            inflight_q   <= 1'b0;
            count_q      <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            done_q       <= 1'b0;
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
        end else begin
            state_q      <= state_d;
            issue_q      <= issue_d;
            addr_q       <= addr_d;
            bytes_read_q <= bytes_read_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            done_q       <= done_d;
            if (push) begin
                mem_q[wr_ptr_q] <= buffer_data_in;
            end
        end
    end

    assign buffer_read_enable_out = strobe;
    assign buffer_address_out     = strobe ? issue_q : addr_q;
    assign data_out               = mem_q[rd_ptr_q];
    assign data_valid_out         = valid;
    assign bytes_read_out         = bytes_read_q;
    assign busy_out               = (state_q == ST_STREAM);
    assign done_out               = done_q;

endmodule

// File: tb/tb_image_buffer_reader.sv
// Bench for image_buffer_reader: buffer model returns byte k = k & 0xFF one cycle after each strobe.
module tb_image_buffer_reader;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] avail;
    logic          complete;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] buf_data;
    logic [DW-1:0] dout;
    logic          dvalid;
    logic          dready;
    logic [AW-1:0] bytes_read;
    logic          busy;
    logic          done;

    image_buffer_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock_in              (clk),
        .reset_n_in            (rst_n),
        .start_in              (start),
        .abort_in              (abort),
        .bytes_available_in    (avail),
        .image_complete_in     (complete),
        .buffer_read_enable_out(rd_en),
        .buffer_address_out    (rd_addr),
        .buffer_data_in        (buf_data),
        .data_out              (dout),
        .data_valid_out        (dvalid),
        .data_ready_in         (dready),
        .bytes_read_out        (bytes_read),
        .busy_out              (busy),
        .done_out              (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: data follows the strobe by exactly one cycle, junk otherwise.
    always @(posedge clk) begin
        if (rd_en) buf_data <= rd_addr[7:0];
        else       buf_data <= 8'($urandom);
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    exp_q[$];
    logic [AW-1:0] exp_addr;
    int            xfer_cnt, strobe_cnt, done_cnt, valid_cycles;
    int            first_strobe, first_valid, done_cyc, last_xfer;
    bit            stall_prev;
    logic [DW-1:0] stall_data;

    task automatic sb_clear();
        exp_q.delete();
        exp_addr     = '0;
        xfer_cnt     = 0;
        strobe_cnt   = 0;
        done_cnt     = 0;
        valid_cycles = 0;
        first_strobe = -1;
        first_valid  = -1;
        done_cyc     = -1;
        last_xfer    = -1;
        stall_prev   = 1'b0;
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            automatic int occ = exp_q.size();
            if (dvalid) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (stall_prev) begin
                n_checks++;
                if (!dvalid || dout !== stall_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%0b data=%02h required valid=1 data=%02h", dvalid, dout, stall_data);
                end
            end
            stall_prev = dvalid && !dready;
            stall_data = dout;
            if (dvalid && dready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL xfer_unexpected: got byte %02h required no transfer", dout);
                end else begin
                    automatic logic [7:0] e = exp_q.pop_front();
                    if (dout !== e) begin
                        n_fail++;
                        $display("FAIL xfer_data: got %02h required %02h", dout, e);
                    end
                end
                xfer_cnt++;
                last_xfer = cyc;
            end
            if (rd_en) begin
                n_checks++;
                if (rd_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL strobe_addr: got %0d required %0d", rd_addr, exp_addr);
                end
                n_checks++;
                if (occ >= 2) begin
                    n_fail++;
                    $display("FAIL outstanding: got %0d before strobe required < 2", occ);
                end
                exp_q.push_back(exp_addr[7:0]);
                exp_addr = exp_addr + 1'b1;
                strobe_cnt++;
                if (first_strobe < 0) first_strobe = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n, input bit cmpl, output int n_cyc);
        avail    = AW'(n);
        complete = cmpl;
        start    = 1'b1;
        n_cyc    = cyc;
        sb_clear();
        step();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; abort = 0; avail = '0; complete = 0; dready = 0;
        sb_clear();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({rd_en, rd_addr, dout, dvalid, bytes_read, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%0b addr=%0d data=%0h valid=%0b read=%0d busy=%0b done=%0b required all 0",
                     rd_en, rd_addr, dout, dvalid, bytes_read, busy, done);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int n; bit ok;
        dready = 1'b1;
        do_start(300, 1'b1, n);
        wait_done(3000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: got no done required done"); end
        n_checks++; if (first_strobe != n + 1) begin n_fail++; $display("FAIL basic_first_strobe: got %0d required %0d", first_strobe, n + 1); end
        n_checks++; if (first_valid != n + 3) begin n_fail++; $display("FAIL basic_first_valid: got %0d required %0d", first_valid, n + 3); end
        n_checks++; if (xfer_cnt != 300) begin n_fail++; $display("FAIL basic_xfers: got %0d required 300", xfer_cnt); end
        n_checks++; if (done_cyc != last_xfer + 1) begin n_fail++; $display("FAIL basic_done_cycle: got %0d required %0d", done_cyc, last_xfer + 1); end
        step();
        n_checks++; if (bytes_read !== 16'd300) begin n_fail++; $display("FAIL basic_bytes_read: got %0d required 300", bytes_read); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %0b required 0", busy); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d required 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        int n; bit ok;
        dready = 1'b1;
        do_start(10, 1'b1, n);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            dready = ((k % 4) == 0) || ((k % 4) == 3);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        dready = 1'b1;
        repeat (3) step();
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_done_timeout: got no done required done"); end
        n_checks++; if (xfer_cnt != 10) begin n_fail++; $display("FAIL bp_xfers: got %0d required 10", xfer_cnt); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d required 1", done_cnt); end
        n_checks++; if (done_cyc != last_xfer + 1) begin n_fail++; $display("FAIL bp_done_cycle: got %0d required %0d", done_cyc, last_xfer + 1); end
        n_checks++; if (bytes_read !== 16'd10) begin n_fail++; $display("FAIL bp_bytes_read: got %0d required 10", bytes_read); end
    endtask

    task automatic test_growing();
        int n, s10; bit ok;
        dready = 1'b1;
        do_start(4, 1'b0, n);
        while (cyc < n + 10) step();
        s10 = strobe_cnt;
        while (cyc < n + 40) step();
        n_checks++; if (s10 != 4 || strobe_cnt != 4) begin n_fail++; $display("FAIL grow_stall_strobes: got %0d/%0d required 4/4", s10, strobe_cnt); end
        n_checks++; if (xfer_cnt != 4 || busy !== 1'b1) begin n_fail++; $display("FAIL grow_first_part: got xfers=%0d busy=%0b required 4 and 1", xfer_cnt, busy); end
        avail = 16'd9;
        while (cyc < n + 60) step();
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL grow_early_done: got %0d required 0", done_cnt); end
        complete = 1'b1;
        wait_done(200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL grow_done_timeout: got no done required done"); end
        n_checks++; if (done_cyc != n + 61) begin n_fail++; $display("FAIL grow_done_cycle: got %0d required %0d", done_cyc, n + 61); end
        n_checks++; if (xfer_cnt != 9 || bytes_read !== 16'd9) begin n_fail++; $display("FAIL grow_total: got xfers=%0d read=%0d required 9", xfer_cnt, bytes_read); end
    endtask

    task automatic test_zero_length();
        int n; bit ok;
        dready = 1'b1;
        do_start(0, 1'b1, n);
        wait_done(20, ok);
        repeat (3) step();
        n_checks++; if (!ok || done_cyc != n + 2) begin n_fail++; $display("FAIL zero_done_cycle: got %0d required %0d", done_cyc, n + 2); end
        n_checks++; if (strobe_cnt != 0 || valid_cycles != 0) begin n_fail++; $display("FAIL zero_activity: got strobes=%0d valid=%0d required 0", strobe_cnt, valid_cycles); end
    endtask

    task automatic test_abort();
        int n; bit ok;
        dready = 1'b1;
        do_start(100, 1'b1, n);
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (dvalid && dready && xfer_cnt == 19) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_reach_timeout: got %0d xfers required 19", xfer_cnt); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++; if (dvalid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_next: got valid=%0b busy=%0b required 0", dvalid, busy); end
        n_checks++; if (xfer_cnt != 20) begin n_fail++; $display("FAIL abort_xfers: got %0d required 20", xfer_cnt); end
        exp_q.delete();
        stall_prev = 1'b0;
        repeat (10) step();
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d required 0", done_cnt); end
        do_start(5, 1'b1, n);
        n_checks++; if (bytes_read !== '0) begin n_fail++; $display("FAIL restart_bytes_read: got %0d required 0", bytes_read); end
        wait_done(200, ok);
        n_checks++; if (!ok || xfer_cnt != 5 || first_strobe != n + 1) begin n_fail++; $display("FAIL restart_run: got xfers=%0d first_strobe=%0d required 5 and %0d", xfer_cnt, first_strobe, n + 1); end
        step();
        n_checks++; if (bytes_read !== 16'd5) begin n_fail++; $display("FAIL restart_bytes_final: got %0d required 5", bytes_read); end
    endtask

    task automatic test_async_reset();
        int n;
        dready = 1'b1;
        do_start(50, 1'b1, n);
        repeat (15) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rd_en, rd_addr, dout, dvalid, bytes_read, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got en=%0b addr=%0d data=%0h valid=%0b read=%0d busy=%0b done=%0b required all 0",
                     rd_en, rd_addr, dout, dvalid, bytes_read, busy, done);
        end
        step();
        sb_clear();
        rst_n = 1'b1;
        step();
        n_checks++; if (busy !== 1'b0 || dvalid !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: got busy=%0b valid=%0b required 0", busy, dvalid); end
        avail = 16'd20;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        repeat (5) step();
        n_checks++; if (busy !== 1'b0 || strobe_cnt != 0 || valid_cycles != 0) begin n_fail++; $display("FAIL start_with_abort: got busy=%0b strobes=%0d valid=%0d required 0", busy, strobe_cnt, valid_cycles); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_growing();
        test_zero_length();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
